// File: rtl/add_sub_unit_pkg.sv
// ---------------------------------------------------------------------------
// add_sub_unit_pkg
// Shared constants for the add/subtract ALU primitive.
//   ALU_WIDTH : default operand/result width
//   OP_ADD    : sub control value selecting a+b
//   OP_SUB    : sub control value selecting a-b
//   is_zero   : helper used for the zero status flag
// ---------------------------------------------------------------------------
package add_sub_unit_pkg;

  localparam int ALU_WIDTH = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // True when every bit of a 32-bit-max vector (masked to width w) is clear.
  function automatic logic is_zero(input logic [31:0] v, input int w);
    logic [31:0] mask;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return ((v & mask) == 32'd0);
  endfunction

endpackage

// File: rtl/add_sub_unit_rca.sv
// ---------------------------------------------------------------------------
// ripple_carry_adder
// Plain ripple chain of full adders.
//   x, y     : WIDTH-bit addends
//   cin      : carry into bit 0
//   sum      : WIDTH-bit sum (modulo 2^WIDTH)
//   cout     : carry out of the MSB
//   c_msb_in : carry into the MSB (paired with cout to detect signed overflow)
// ---------------------------------------------------------------------------
module ripple_carry_adder
  import add_sub_unit_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             c_msb_in
);

  // carry[i] is the carry into bit i; carry[WIDTH] is the final carry out.
  logic [WIDTH:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i]       = x[i] ^ y[i] ^ carry[i];
    assign carry[i + 1] = (x[i] & y[i]) | (carry[i] & (x[i] ^ y[i]));
  end

  assign cout     = carry[WIDTH];
  assign c_msb_in = carry[WIDTH-1];

endmodule

// File: rtl/add_sub_unit.sv
// ---------------------------------------------------------------------------
// add_sub_unit
// Registered two's-complement adder/subtractor with status flags, latency 1.
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset (clears results and flags)
//   in_valid  : operands valid this cycle
//   sub       : 0 -> a+b, 1 -> a-b
//   a, b      : WIDTH-bit two's-complement operands
//   out_valid : result registers hold a new result
//   s         : sum/difference modulo 2^WIDTH
//   ovf       : signed overflow
//   cout      : carry out of MSB (in subtract mode, 1 means no borrow)
//   zero      : s == 0
//   neg       : s[WIDTH-1]
// ---------------------------------------------------------------------------
module add_sub_unit
  import add_sub_unit_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] s,
  output logic             ovf,
  output logic             cout,
  output logic             zero,
  output logic             neg
);

  logic [WIDTH-1:0] bx;
  logic             cin;
  logic [WIDTH-1:0] s_c;
  logic             cout_c;
  logic             c_msb_in_c;
  logic             ovf_c;
  logic             zero_c;
  logic [31:0]      s_ext;

  // Subtraction is a + ~b + 1: the same control inverts b and injects the +1.
  assign cin = (sub == OP_SUB);
  assign bx  = b ^ {WIDTH{cin}};

  ripple_carry_adder #(
    .WIDTH (WIDTH)
  ) u_rca (
    .x        (a),
    .y        (bx),
    .cin      (cin),
    .sum      (s_c),
    .cout     (cout_c),
    .c_msb_in (c_msb_in_c)
  );

  // Signed overflow: carry into the MSB disagrees with carry out of it.
  assign ovf_c = c_msb_in_c ^ cout_c;

  always_comb begin
    s_ext             = '0;
    s_ext[WIDTH-1:0]  = s_c;
  end

  assign zero_c = is_zero(s_ext, WIDTH);

  // ---- stage p0 -> p1 : result and flag registers ----
  logic             vld_p1;
  logic [WIDTH-1:0] s_p1;
  logic             ovf_p1;
  logic             cout_p1;
  logic             zero_p1;
  logic             neg_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      s_p1    <= '0;
      ovf_p1  <= 1'b0;
      cout_p1 <= 1'b0;
      zero_p1 <= 1'b0;
      neg_p1  <= 1'b0;
    end else begin
      vld_p1 <= in_valid;
      // Results hold their last value on idle cycles.
      if (in_valid) begin
        s_p1    <= s_c;
        ovf_p1  <= ovf_c;
        cout_p1 <= cout_c;
        zero_p1 <= zero_c;
        neg_p1  <= s_c[WIDTH-1];
      end
    end
  end

  assign out_valid = vld_p1;
  assign s         = s_p1;
  assign ovf       = ovf_p1;
  assign cout      = cout_p1;
  assign zero      = zero_p1;
  assign neg       = neg_p1;

endmodule

// File: tb/tb_add_sub_unit.sv
// ---------------------------------------------------------------------------
// tb_add_sub_unit
// Directed-vector bench for add_sub_unit at WIDTH=4, plus a full sweep of
// operand pairs against an integer reference.
// ---------------------------------------------------------------------------
module tb_add_sub_unit;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic [W-1:0] s;
  logic         ovf;
  logic         cout;
  logic         zero;
  logic         neg;

  int n_checks = 0;
  int n_errors = 0;

  add_sub_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .sub       (sub),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .s         (s),
    .ovf       (ovf),
    .cout      (cout),
    .zero      (zero),
    .neg       (neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Packed view {out_valid, s, cout, ovf, zero, neg}.
  function automatic logic [31:0] pack(input logic v, input logic [W-1:0] sv,
                                       input logic c, input logic o,
                                       input logic z, input logic n);
    return {23'd0, v, sv, c, o, z, n};
  endfunction

  function automatic logic [31:0] dut_state();
    return pack(out_valid, s, cout, ovf, zero, neg);
  endfunction

  // Present one operation on a negedge, then sample just after the capturing edge.
  task automatic op(input logic v, input logic m, input logic [W-1:0] av, input logic [W-1:0] bv);
    @(negedge clk);
    in_valid = v;
    sub      = m;
    a        = av;
    b        = bv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ai, bi, res, sa, sb;
    logic [W-1:0] es;
    logic ec, eo;

    rst_n    = 1'b0;
    in_valid = 1'b0;
    sub      = 1'b0;
    a        = '0;
    b        = '0;

    repeat (2) @(posedge clk);
    #1;
    check("reset_state", dut_state(), pack(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0));

    @(negedge clk);
    rst_n = 1'b1;

    // Load a nonzero result, then reset mid-stream with in_valid still high.
    op(1'b1, 1'b0, 4'b0111, 4'b0001);
    check("pre_reset", dut_state(), pack(1'b1, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b1));
    op(1'b1, 1'b0, 4'b0101, 4'b0001);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", dut_state(), pack(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    check("reset_held", dut_state(), pack(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("first_capture", dut_state(), pack(1'b1, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0));

    // Subtract cases.
    op(1'b1, 1'b1, 4'b1111, 4'b1110);
    check("sub_m1_m2", dut_state(), pack(1'b1, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0));
    op(1'b1, 1'b1, 4'b0011, 4'b0001);
    check("sub_3_1", dut_state(), pack(1'b1, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0));
    op(1'b1, 1'b1, 4'b1000, 4'b1010);
    check("sub_m8_m6", dut_state(), pack(1'b1, 4'b1110, 1'b0, 1'b0, 1'b0, 1'b1));
    op(1'b1, 1'b1, 4'b1000, 4'b0001);
    check("sub_m8_1", dut_state(), pack(1'b1, 4'b0111, 1'b1, 1'b1, 1'b0, 1'b0));
    op(1'b1, 1'b1, 4'b0010, 4'b0101);
    check("sub_2_5", dut_state(), pack(1'b1, 4'b1101, 1'b0, 1'b0, 1'b0, 1'b1));
    op(1'b1, 1'b1, 4'b0000, 4'b1000);
    check("sub_0_m8", dut_state(), pack(1'b1, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b1));
    op(1'b1, 1'b1, 4'b0101, 4'b0101);
    check("sub_a_a", dut_state(), pack(1'b1, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0));

    // Add cases.
    op(1'b1, 1'b0, 4'b0111, 4'b0001);
    check("add_7_1", dut_state(), pack(1'b1, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b1));
    op(1'b1, 1'b0, 4'b1111, 4'b0001);
    check("add_m1_1", dut_state(), pack(1'b1, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0));

    // Streaming: four back-to-back operations, one result per cycle.
    op(1'b1, 1'b0, 4'b0001, 4'b0010);
    check("stream0", dut_state(), pack(1'b1, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b0));
    op(1'b1, 1'b1, 4'b0100, 4'b0110);
    check("stream1", dut_state(), pack(1'b1, 4'b1110, 1'b0, 1'b0, 1'b0, 1'b1));
    op(1'b1, 1'b0, 4'b1100, 4'b1100);
    check("stream2", dut_state(), pack(1'b1, 4'b1000, 1'b1, 1'b0, 1'b0, 1'b1));
    op(1'b1, 1'b1, 4'b0110, 4'b0010);
    check("stream3", dut_state(), pack(1'b1, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0));

    // Idle cycle: out_valid drops, result holds even with new operands and sub flipped.
    op(1'b0, 1'b0, 4'b1111, 4'b1111);
    check("idle_hold", dut_state(), pack(1'b0, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0));
    op(1'b0, 1'b1, 4'b0000, 4'b0011);
    check("idle_hold2", dut_state(), pack(1'b0, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0));

    // Full sweep against an integer reference.
    for (int m = 0; m < 2; m++) begin
      for (ai = 0; ai < 16; ai++) begin
        for (bi = 0; bi < 16; bi++) begin
          op(1'b1, m[0], ai[W-1:0], bi[W-1:0]);
          sa  = (ai >= 8) ? ai - 16 : ai;
          sb  = (bi >= 8) ? bi - 16 : bi;
          res = (m == 1) ? (sa - sb) : (sa + sb);
          eo  = (res > 7) || (res < -8);
          es  = res[W-1:0];
          if (m == 1) ec = (ai >= bi);
          else        ec = ((ai + bi) >= 16);
          check($sformatf("sweep m=%0d a=%0h b=%0h", m, ai, bi), dut_state(),
                pack(1'b1, es, ec, eo, (es == 4'b0000), es[W-1]));
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
